// File: rtl/kronos_arb_pkg.sv
// kronos_arb_pkg
//   Shared types and constants for the Kronos instruction/data memory arbiter.
//   grant_t   : registered grant state, i.e. which channel was issued to
//               memory in the previous cycle (and is therefore acked now).
//   FULL_MASK : byte mask driven for instruction fetches (always whole word).
package kronos_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GNT_INSTR = 2'd1,
      GNT_DATA  = 2'd2
   } grant_t;

   localparam logic [3:0] FULL_MASK = 4'hF;

endpackage

// File: rtl/kronos_arb_starve_ctr.sv
// kronos_arb_starve_ctr
//   Anti-starvation guard for instruction fetch. Counts consecutive cycles in
//   which a fetch is pending but loses arbitration. Once the count reaches
//   MAX_STARVE, force_instr is raised for as long as the fetch is pending;
//   the fetch then wins, which clears the count, so exactly one grant is
//   forced per saturation.
//   Only built when KRONOS_ARB_STARVE_GUARD_EN is defined.
// Ports:
//   clk           in   clock
//   rstz          in   synchronous active-low reset
//   instr_req     in   fetch request pending this cycle
//   instr_granted in   fetch is the arbitration winner this cycle
//   force_instr   out  fetch must win this cycle
module kronos_arb_starve_ctr
   import kronos_arb_pkg::*;
#(
   parameter int MAX_STARVE = 4
) (
   input  logic clk,
   input  logic rstz,
   input  logic instr_req,
   input  logic instr_granted,
   output logic force_instr
);

   localparam int            CW      = $clog2(MAX_STARVE + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STARVE);

   logic [CW-1:0] starve_cnt;

   always_ff @(posedge clk) begin
      if (!rstz) begin
         starve_cnt <= '0;
      end else if (!instr_req || instr_granted) begin
         starve_cnt <= '0;
      end else if (starve_cnt != CNT_MAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign force_instr = instr_req && (starve_cnt == CNT_MAX);

endmodule

// File: rtl/kronos_mem_arbiter.sv
// kronos_mem_arbiter
//   Shares one single-port synchronous memory (1-cycle read latency) between
//   the Kronos instruction-fetch and load/store buses.
//   Each cycle one winner is issued combinationally (data has priority);
//   the winner is registered in the grant state and acked the next cycle,
//   when the memory read data is also valid. Losers simply retry.
//   Handshake: a master raises req with its address/data and holds all of
//   them stable until it sees ack. ack is a one-cycle pulse exactly one
//   cycle after issue. A req still high in its ack cycle is a new request
//   and may be issued in that same cycle (1 access/cycle throughput).
//   Optional macro KRONOS_ARB_STARVE_GUARD_EN: after MAX_STARVE consecutive
//   lost fetch cycles the fetch is forced to win one grant.
// Ports:
//   clk, rstz                          clock, synchronous active-low reset
//   instr_addr/req -> instr_data/ack   fetch channel
//   data_addr/wr_data/mask/wr_en/req
//     -> data_rd_data/ack              load/store channel
//   mem_addr/wr_data/mask/en/wr_en     memory command (combinational)
//   mem_rd_data                        memory read data (1 cycle after mem_en)
//   dbg_grant                          grant state register
module kronos_mem_arbiter
   import kronos_arb_pkg::*;
#(
   parameter int MAX_STARVE = 4,
   parameter int AW         = 32
) (
   input  logic          clk,
   input  logic          rstz,
   input  logic [31:0]   instr_addr,
   input  logic          instr_req,
   output logic [31:0]   instr_data,
   output logic          instr_ack,
   input  logic [31:0]   data_addr,
   input  logic [31:0]   data_wr_data,
   input  logic [3:0]    data_mask,
   input  logic          data_wr_en,
   input  logic          data_req,
   output logic [31:0]   data_rd_data,
   output logic          data_ack,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wr_data,
   output logic [3:0]    mem_mask,
   output logic          mem_en,
   output logic          mem_wr_en,
   input  logic [31:0]   mem_rd_data,
   output grant_t        dbg_grant
);

   grant_t grant;
   grant_t grant_next;
   grant_t winner;
   logic   force_instr;

`ifdef KRONOS_ARB_STARVE_GUARD_EN
   kronos_arb_starve_ctr #(
      .MAX_STARVE (MAX_STARVE)
   ) u_starve_ctr (
      .clk           (clk),
      .rstz          (rstz),
      .instr_req     (instr_req),
      .instr_granted (winner == GNT_INSTR),
      .force_instr   (force_instr)
   );
`else
   logic unused_starve_cfg;
   assign unused_starve_cfg = (MAX_STARVE > 0);
   assign force_instr       = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstz) begin
         grant <= IDLE;
      end else begin
         grant <= grant_next;
      end
   end

   always_comb begin
      winner      = IDLE;
      mem_addr    = '0;
      mem_wr_data = '0;
      mem_mask    = '0;
      mem_wr_en   = 1'b0;

      if (force_instr) begin
         winner = GNT_INSTR;
      end else if (data_req) begin
         winner = GNT_DATA;
      end else if (instr_req) begin
         winner = GNT_INSTR;
      end

      // Memory is held off for the whole reset cycle so nothing in flight
      // can be acked afterwards.
      mem_en = rstz && (winner != IDLE);

      case (winner)
         GNT_DATA: begin
            mem_addr    = AW'(data_addr);
            mem_wr_data = data_wr_data;
            mem_mask    = data_mask;
            mem_wr_en   = mem_en && data_wr_en;
         end
         GNT_INSTR: begin
            mem_addr = AW'(instr_addr);
            mem_mask = FULL_MASK;
         end
         default: ;
      endcase

      grant_next = mem_en ? winner : IDLE;
   end

   assign instr_ack    = (grant == GNT_INSTR);
   assign data_ack     = (grant == GNT_DATA);
   assign instr_data   = mem_rd_data;
   assign data_rd_data = mem_rd_data;
   assign dbg_grant    = grant;

endmodule
